// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces keys/switches, turns key presses into
// one-deep buffered single-cycle commands, and decodes the algorithm switches.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ISSUE_GAP       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] key_n,
    input  logic [3:0] sw,
    input  logic       busy,
    output logic       return_pulse,
    output logic       zoom_in_pulse,
    output logic       zoom_out_pulse,
    output logic       cmd_pending,
    output logic [1:0] algorithm_select,
    output logic       multiple_switches_error,
    output logic       no_switch_selected_error
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = ISSUE_GAP > 0 ? $clog2(ISSUE_GAP + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    // bits [2:0] are the active-low keys (released = 1), bits [6:3] the switches
    localparam logic [6:0] RST = 7'b0000111;

    typedef enum logic [1:0] {S_NONE, S_RET, S_ZI, S_ZO} slot_t;

    logic [6:0]    s1, s2, st;
    logic [CW-1:0] cnt [7];
    logic [2:0]    key_prev, ev;
    logic [2:0]    pc;
    logic [HW-1:0] hold;
    logic          issue, sw_err;
    slot_t         slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= RST;
            s2 <= RST;
        end else begin
            s1 <= {sw, key_n};
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 7; k++) begin
            if (reset) begin
                cnt[k] <= '0;
                st[k]  <= RST[k];
            end else if (s2[k] == st[k]) begin
                cnt[k] <= '0;
            end else if (cnt[k] == CMAX) begin
                cnt[k] <= '0;
                st[k]  <= ~st[k];
            end else begin
                cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) key_prev <= reset ? 3'b111 : st[2:0];

    always_comb begin
        ev     = key_prev & ~st[2:0];
        pc     = 3'(st[3]) + 3'(st[4]) + 3'(st[5]) + 3'(st[6]);
        sw_err = multiple_switches_error | no_switch_selected_error;
        issue  = slot != S_NONE && !busy && hold == '0;
    end

    // A full slot ignores new events; switch errors gate zoom commands only.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot           <= S_NONE;
            hold           <= '0;
            return_pulse   <= 1'b0;
            zoom_in_pulse  <= 1'b0;
            zoom_out_pulse <= 1'b0;
        end else begin
            return_pulse   <= issue && slot == S_RET;
            zoom_in_pulse  <= issue && slot == S_ZI;
            zoom_out_pulse <= issue && slot == S_ZO;
            if (issue) begin
                slot <= S_NONE;
                hold <= HW'(ISSUE_GAP);
            end else begin
                if (hold != '0) hold <= hold - 1'b1;
                if (slot == S_NONE)
                    slot <= ev[0] ? S_RET : sw_err ? S_NONE : ev[1] ? S_ZI : ev[2] ? S_ZO : S_NONE;
            end
        end
    end

    assign cmd_pending = slot != S_NONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            algorithm_select         <= 2'b00;
            multiple_switches_error  <= 1'b0;
            no_switch_selected_error <= 1'b1;
        end else begin
            algorithm_select         <= st[3] ? 2'd0 : st[4] ? 2'd1 : st[5] ? 2'd2 : st[6] ? 2'd3 : 2'd0;
            multiple_switches_error  <= pc > 3'd1;
            no_switch_selected_error <= pc == 3'd0;
        end
    end
endmodule
